fp_compare_issue: RTL and testbench

Issue/collect front end for a fixed-latency, non-stallable floating-point compare pipeline (the `a`/`b`/`q` less-than unit with `LATENCY` cycles). Accepts tagged operand pairs over a valid/ready handshake, drives them into the pipeline, tracks in-flight slots with a valid/tag delay line, and lands results in a small FIFO that presents a valid/ready result stream. Credit accounting guarantees a result is never dropped when the consumer stalls, because the compare pipeline itself cannot stall.

---
 rtl/fp_unit_pkg.sv | 10 +
 rtl/fp_result_fifo.sv | 63 ++++++
 rtl/fp_compare_issue.sv | 107 ++++++++++
 tb/tb_fp_compare_issue.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_unit_pkg.sv
// Shared floating-point unit definitions: word width, default compare
// pipeline latency and the single-precision word type.
package fp_unit_pkg;

    localparam int FP_WIDTH       = 32;
    localparam int FP_CMP_LATENCY = 2;

    typedef logic [FP_WIDTH-1:0] fp_word_t;

endpackage

// File: rtl/fp_result_fifo.sv
// Small circular result FIFO with registered pointers and an occupancy count.
// Reads are first-word-fall-through; the head reads as zero while empty so
// that downstream data outputs are quiet during and after reset.
module fp_result_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only legal when a pop frees a slot the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Storage write; contents need no reset because the count masks them.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fp_compare_issue.sv
// Issue/collect front end for a fixed-latency, non-stallable FP less-than
// pipeline. Requests are tagged, tracked through a valid/tag delay line that
// mirrors the pipeline depth, and results land in a small FIFO. A request is
// only accepted when a FIFO slot is guaranteed for it (in-flight + queued <
// FIFO_DEPTH), so a stalled consumer can never cause a result to be dropped.
//
// Handshakes: both the request side (in_valid/in_ready) and the result side
// (out_valid/out_ready) transfer exactly on a rising clock edge where valid and
// ready are both high; valid never depends on ready, and in_ready is a function
// of registered state only (no out_ready -> in_ready path).
module fp_compare_issue
    import fp_unit_pkg::*;
#(
    parameter int LATENCY    = FP_CMP_LATENCY,
    parameter int TAG_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  fp_word_t             in_a,
    input  fp_word_t             in_b,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output fp_word_t             pipe_a,
    output fp_word_t             pipe_b,
    input  logic                 pipe_q,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_q,
    output logic [TAG_WIDTH-1:0] out_tag
);

    localparam int IW = $clog2(LATENCY + 1);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    if (LATENCY < 1) begin : g_bad_latency
        $error("fp_compare_issue: LATENCY must be at least 1");
    end
    if (FIFO_DEPTH < 1) begin : g_bad_depth
        $error("fp_compare_issue: FIFO_DEPTH must be at least 1");
    end

    logic                 issue;
    logic                 pop;
    logic [LATENCY-1:0]   v;
    logic [TAG_WIDTH-1:0] tag_line [LATENCY];
    logic [IW-1:0]        inflight;
    logic [CW-1:0]        fifo_count;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic [TAG_WIDTH:0]   head;
    logic [31:0]          credits_used;

    // Operands go straight to the pipeline; the valid line masks idle cycles.
    assign pipe_a = in_a;
    assign pipe_b = in_b;

    assign credits_used = 32'(inflight) + 32'(fifo_count);
    assign in_ready     = credits_used < 32'(FIFO_DEPTH);
    assign issue        = in_valid && in_ready;

    assign out_valid        = !fifo_empty;
    assign pop              = out_valid && out_ready;
    assign {out_q, out_tag} = head;

    // Valid delay line and in-flight counter, cleared on reset so that
    // results still travelling through the pipeline are discarded.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v        <= '0;
            inflight <= '0;
        end else begin
            v        <= (v << 1) | LATENCY'(issue);
            inflight <= inflight + IW'(issue) - IW'(v[LATENCY-1]);
        end
    end

    // Tag delay line; only meaningful where the matching valid bit is set.
    always_ff @(posedge clock) begin
        tag_line[0] <= in_tag;
        for (int i = 1; i < LATENCY; i++) begin
            tag_line[i] <= tag_line[i-1];
        end
    end

    fp_result_fifo #(
        .WIDTH (TAG_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (v[LATENCY-1]),
        .wr_data ({pipe_q, tag_line[LATENCY-1]}),
        .pop     (pop),
        .rd_data (head),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // The credit rule makes a landing result into a full, non-draining FIFO impossible.
    push_never_overflows: assert property (
        @(posedge clock) disable iff (reset) !(v[LATENCY-1] && fifo_full && !pop)
    );

endmodule

// File: tb/tb_fp_compare_issue.sv
// Directed bench for fp_compare_issue with a behavioural LATENCY=2 less-than
// unit attached to the pipe ports and a scoreboard of expected {q, tag}.
module tb_fp_compare_issue;

    localparam int L = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [7:0]  in_tag;
    logic [31:0] pipe_a;
    logic [31:0] pipe_b;
    logic        pipe_q;
    logic        out_valid;
    logic        out_ready;
    logic        out_q;
    logic [7:0]  out_tag;

    int total = 0;
    int bad = 0;
    int deq_count = 0;

    logic [8:0] exp_q[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  tag;
        logic        want_q;
    } vec_t;

    vec_t vecs[10];

    fp_compare_issue #(
        .LATENCY    (L),
        .TAG_WIDTH  (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .pipe_a    (pipe_a),
        .pipe_b    (pipe_b),
        .pipe_q    (pipe_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q),
        .out_tag   (out_tag)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural compare unit ----------------
    function automatic bit fp_lt(input logic [31:0] a, input logic [31:0] b);
        bit a_nan;
        bit b_nan;
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        if (a_nan || b_nan) return 1'b0;
        if (a[30:0] == 31'd0 && b[30:0] == 31'd0) return 1'b0;
        if (a[31] != b[31]) return a[31];
        if (!a[31]) return a[30:0] < b[30:0];
        return a[30:0] > b[30:0];
    endfunction

    bit q_stage [L];
    always @(posedge clock) begin
        q_stage[0] <= fp_lt(pipe_a, pipe_b);
        for (int i = 1; i < L; i++) q_stage[i] <= q_stage[i-1];
    end
    assign pipe_q = q_stage[L-1];

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] b,
                         input logic [7:0] t);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_tag   = t;
    endtask

    // Called after inputs are set for the cycle: records an accepted request.
    task automatic offer(input logic want, output bit took);
        took = in_valid && in_ready;
        if (took) exp_q.push_back({want, in_tag});
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clock) begin : sb
        logic [8:0] e;
        if (!reset && out_valid && out_ready) begin
            deq_count++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL result: unexpected q=%0d tag=%0h with nothing expected",
                         out_q, out_tag);
            end else begin
                e = exp_q.pop_front();
                if ({out_q, out_tag} !== e) begin
                    bad++;
                    $display("FAIL result: got q=%0d tag=%0h want q=%0d tag=%0h",
                             out_q, out_tag, e[8], e[7:0]);
                end
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        bit took;
        int lat;
        int rdy_low;
        int gaps;
        int accepted;
        int first_low;
        int deq_before;
        int n;
        int seen;
        logic [31:0] a;
        logic [31:0] b;

        vecs[0] = '{32'h3F800000, 32'h40000000, 8'h11, 1'b1}; // 1.0 < 2.0
        vecs[1] = '{32'h40000000, 32'h3F800000, 8'h12, 1'b0}; // 2.0 < 1.0
        vecs[2] = '{32'h7FC00000, 32'h3F800000, 8'h13, 1'b0}; // NaN < 1.0
        vecs[3] = '{32'hBF800000, 32'h3F800000, 8'h14, 1'b1}; // -1.0 < 1.0
        vecs[4] = '{32'h00000000, 32'h80000000, 8'h15, 1'b0}; // +0 < -0
        vecs[5] = '{32'hC0000000, 32'hBF800000, 8'h16, 1'b1}; // -2.0 < -1.0
        vecs[6] = '{32'h3F800000, 32'h3F800000, 8'h17, 1'b0}; // 1.0 < 1.0
        vecs[7] = '{32'h7F800000, 32'h3F800000, 8'h18, 1'b0}; // +inf < 1.0
        vecs[8] = '{32'h3F800000, 32'h7F800000, 8'h19, 1'b1}; // 1.0 < +inf
        vecs[9] = '{32'h3F800000, 32'h7FC00000, 8'h1A, 1'b0}; // 1.0 < NaN

        reset     = 1'b1;
        out_ready = 1'b0;
        drive(0, 32'd0, 32'd0, 8'd0);
        step();
        step();
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_q", out_q, 0);
        check("reset_out_tag", out_tag, 0);
        reset = 1'b0;
        step();

        // Table: single requests, latency and result per vector.
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            drive(1, vecs[i].a, vecs[i].b, vecs[i].tag);
            offer(vecs[i].want_q, took);
            check("tbl_accept", took, 1);
            step();
            drive(0, 32'd0, 32'd0, 8'd0);
            lat = 1;
            while (!out_valid && lat < 10) begin
                step();
                lat++;
            end
            check("tbl_latency", lat, 3);
            step();
        end

        // Streaming: 100 back-to-back requests with the consumer always ready.
        rdy_low = 0;
        gaps    = 0;
        for (int i = 0; i < 103; i++) begin
            if (i < 100) begin
                a = $urandom;
                b = $urandom;
                drive(1, a, b, 8'(i));
                offer(fp_lt(a, b), took);
                if (!took) rdy_low++;
            end else begin
                drive(0, 32'd0, 32'd0, 8'd0);
            end
            if (i >= 3 && !out_valid) gaps++;
            step();
        end
        check("stream_ready_low", rdy_low, 0);
        check("stream_gaps", gaps, 0);
        step();
        check("stream_drained", exp_q.size(), 0);

        // Backpressure: consumer stalled, exactly FIFO_DEPTH accepted.
        out_ready = 1'b0;
        accepted  = 0;
        first_low = -1;
        for (int i = 0; i < 8; i++) begin
            drive(1, 32'h3F800000, 32'h40000000, 8'(8'h40 + i));
            offer(1'b1, took);
            if (took) accepted++;
            else if (first_low < 0) first_low = i;
            step();
        end
        drive(0, 32'd0, 32'd0, 8'd0);
        check("bp_accepted", accepted, 4);
        check("bp_first_low", first_low, 4);
        step();
        step();
        out_ready = 1'b1;
        check("bp_ready_before_pop", in_ready, 0);
        step();
        check("bp_ready_after_pop", in_ready, 1);
        for (int i = 0; i < 4; i++) step();
        check("bp_drained", exp_q.size(), 0);
        check("bp_out_valid_idle", out_valid, 0);

        // Simultaneous push/pop with alternating consumer readiness.
        deq_before = deq_count;
        accepted   = 0;
        for (int i = 0; i < 40; i++) begin
            out_ready = i[0];
            a = $urandom;
            b = $urandom;
            drive(1, a, b, 8'(8'h80 + i));
            offer(fp_lt(a, b), took);
            if (took) accepted++;
            step();
        end
        drive(0, 32'd0, 32'd0, 8'd0);
        out_ready = 1'b1;
        n = 0;
        while ((out_valid || exp_q.size() != 0) && n < 20) begin
            step();
            n++;
        end
        check("alt_drained", exp_q.size(), 0);
        check("alt_deq_count", deq_count - deq_before, accepted);

        // Reset with two results queued and two still in the pipeline.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1, 32'h3F800000, 32'h40000000, 8'(8'h50 + i));
            offer(1'b1, took);
            step();
        end
        drive(0, 32'd0, 32'd0, 8'd0);
        step();
        step();
        check("rst_pre_out_valid", out_valid, 1);
        for (int i = 0; i < 2; i++) begin
            drive(1, 32'h3F800000, 32'h40000000, 8'(8'h52 + i));
            offer(1'b1, took);
            step();
        end
        drive(0, 32'd0, 32'd0, 8'd0);
        reset = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_q", out_q, 0);
        check("rst_out_tag", out_tag, 0);
        exp_q.delete();
        step();
        reset     = 1'b0;
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) seen++;
            step();
        end
        check("rst_late_pulses", seen, 0);
        check("rst_after_in_ready", in_ready, 1);

        // Recovery after reset.
        drive(1, 32'h3F800000, 32'h40000000, 8'h60);
        offer(1'b1, took);
        check("rec_accept", took, 1);
        step();
        drive(0, 32'd0, 32'd0, 8'd0);
        lat = 1;
        while (!out_valid && lat < 10) begin
            step();
            lat++;
        end
        check("rec_latency", lat, 3);
        step();
        step();
        check("final_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
